// File: rtl/s2p_pkg.sv
// s2p_pkg: shared definitions for the serial-to-parallel receiver.
//   - s2p_state_e   : receiver state encoding (ST_IDLE, ST_RECV, ST_DONE)
//   - S2P_CNT_W     : width of the received-bit counter and of S2P_Bit_Cnt
//   - S2P_SYNC_STAGES_DEF : default depth of each input synchroniser
//   - s2p_frame_err : bad-frame rule evaluated when a frame closes
package s2p_pkg;

  localparam int S2P_CNT_W           = 8;
  localparam int S2P_SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } s2p_state_e;

  // A frame is bad when nothing was clocked in, when bits were dropped, or
  // when the count disagrees with the width latched at frame start. A
  // latched width of 0 or above the register size can never match a clean
  // count, so it is caught by the same comparison.
  function automatic logic s2p_frame_err(input logic [S2P_CNT_W-1:0] cnt,
                                         input logic [31:0]          width,
                                         input logic                 ovf);
    return ovf || (cnt == '0) || ({{(32-S2P_CNT_W){1'b0}}, cnt} != width);
  endfunction

endpackage

// File: rtl/s2p_sync_edge.sv
// s2p_sync_edge: N-stage synchroniser for one asynchronous line, followed by
// one edge-detect register and registered rise/fall pulses.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-low reset (clears the whole chain)
//   i_async in   asynchronous input line
//   o_level out  synchronised level
//   o_rise  out  one-cycle pulse after a synchronised 0->1 transition
//   o_fall  out  one-cycle pulse after a synchronised 1->0 transition
module s2p_sync_edge
  import s2p_pkg::*;
#(
  parameter int STAGES = S2P_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;
  logic              w_level;

  assign w_level = r_sync[STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= w_level;
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign o_level = w_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/s2p_width_rc_module.sv
// s2p_width_rc_module: oversampling serial-to-parallel receiver with a
// run-time frame width. Frames are bracketed by Serial_data_en; data is
// taken on each Serial_clk rising edge.
// Optional build macro: S2P_TIMEOUT_EN adds a watchdog that aborts a frame
// after TIMEOUT_CYCLES clk cycles without a serial-clock rising edge.
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   Serial_clk      serial clock (async, idle low)
//   Serial_data     serial data, valid at Serial_clk rise
//   Serial_data_en  frame enable, active high
//   S2P_DATA_Width  expected bit count, latched at frame start
//   S2P_DATA_OUT    received word, right-aligned, held until next frame end
//   S2P_Valid       one-cycle strobe when S2P_DATA_OUT updates
//   S2P_BUSY        high while a frame is being received
//   S2P_Err         one-cycle bad-frame pulse (with Valid, or on abort)
//   S2P_Bit_Cnt     bits captured in the last completed frame
//   o_dbg_state     current receiver state
//
// Handshake: S2P_Valid is a single-cycle push with no back-pressure; the
// word and S2P_Bit_Cnt are stable from that cycle until the next Valid.
module s2p_width_rc_module
  import s2p_pkg::*;
#(
  parameter int SHIFT_REG_WIDTH_MAX = 16,
  parameter int SYNC_STAGES         = S2P_SYNC_STAGES_DEF,
  parameter int FIRST_BIT_MSB       = 1,
  parameter int TIMEOUT_CYCLES      = 2000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Serial_clk,
  input  logic                           Serial_data,
  input  logic                           Serial_data_en,
  input  logic [31:0]                    S2P_DATA_Width,
  output logic [SHIFT_REG_WIDTH_MAX-1:0] S2P_DATA_OUT,
  output logic                           S2P_Valid,
  output logic                           S2P_BUSY,
  output logic                           S2P_Err,
  output logic [S2P_CNT_W-1:0]           S2P_Bit_Cnt,
  output s2p_state_e                     o_dbg_state
);

  localparam logic [S2P_CNT_W-1:0] CNT_MAX = S2P_CNT_W'(SHIFT_REG_WIDTH_MAX);
  localparam logic [S2P_CNT_W-1:0] CNT_SAT = S2P_CNT_W'(SHIFT_REG_WIDTH_MAX + 1);
  localparam int                   WARM_W  = SYNC_STAGES + 2;

  // ---------------- input synchronisers ----------------
  logic w_clk_rise, w_unused_clk_level, w_unused_clk_fall;
  logic w_en_level, w_en_rise, w_en_fall;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic w_data;

  s2p_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .i_async(Serial_clk),
    .o_level(w_unused_clk_level), .o_rise(w_clk_rise), .o_fall(w_unused_clk_fall)
  );

  s2p_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk(clk), .rst(rst), .i_async(Serial_data_en),
    .o_level(w_en_level), .o_rise(w_en_rise), .o_fall(w_en_fall)
  );

  // Data needs no edge detect; it is one register younger than the clock
  // rise pulse, which is fine because data is stable for a whole phase.
  always_ff @(posedge clk) begin
    if (!rst) r_data_sync <= '0;
    else      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], Serial_data};
  end
  assign w_data = r_data_sync[SYNC_STAGES-1];

  // ---------------- state machine ----------------
  s2p_state_e r_state, w_state_nxt;
  logic       r_need_low;
  logic       w_start_ok, w_start, w_finish, w_abort, w_wd_expire;

  // An enable edge only opens a frame once the receiver has seen the line low.
  assign w_start_ok = w_en_rise && !r_need_low;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_start     = 1'b1;
          w_state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_en_fall) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_wd_expire) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (w_start_ok) begin
          w_start     = 1'b1;
          w_state_nxt = ST_RECV;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- optional watchdog ----------------
`ifdef S2P_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd;

  always_ff @(posedge clk) begin
    if (!rst)                                r_wd <= '0;
    else if (r_state != ST_RECV || w_clk_rise) r_wd <= '0;
    else                                     r_wd <= r_wd + WD_W'(1);
  end

  assign w_wd_expire = (r_state == ST_RECV) && !w_clk_rise &&
                       (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog in this build; the parameter stays in the interface so both
  // builds instantiate identically.
  assign w_wd_expire = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // ---------------- capture datapath ----------------
  logic [SHIFT_REG_WIDTH_MAX-1:0] r_shift, w_shift_nxt;
  logic [S2P_CNT_W-1:0]           r_cnt, w_cnt_nxt;
  logic                           r_ovf, w_ovf_nxt;
  logic [31:0]                    r_width;
  logic [SHIFT_REG_WIDTH_MAX-1:0] r_data_out;
  logic [S2P_CNT_W-1:0]           r_bit_cnt;
  logic                           r_valid, r_err;
  logic [WARM_W-1:0]              r_warm;

  // Next shift/count values include a bit captured in the same cycle as the
  // enable fall, so the closing frame always sees it.
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (r_state == ST_RECV && w_clk_rise) begin
      if (r_cnt < CNT_MAX) begin
        if (FIRST_BIT_MSB != 0) begin
          w_shift_nxt = {r_shift[SHIFT_REG_WIDTH_MAX-2:0], w_data};
        end else begin
          for (int i = 0; i < SHIFT_REG_WIDTH_MAX; i++) begin
            if (r_cnt == S2P_CNT_W'(i)) w_shift_nxt[i] = w_data;
          end
        end
        w_cnt_nxt = r_cnt + S2P_CNT_W'(1);
      end else begin
        w_ovf_nxt = 1'b1;
        w_cnt_nxt = CNT_SAT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_width    <= '0;
      r_data_out <= '0;
      r_bit_cnt  <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_warm     <= '0;
      r_need_low <= 1'b1;
    end else begin
      r_valid <= w_finish;
      r_err   <= (w_finish && s2p_frame_err(w_cnt_nxt, r_width, w_ovf_nxt)) || w_abort;
      if (w_start) begin
        r_width <= S2P_DATA_Width;
        r_shift <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_shift <= w_shift_nxt;
        r_cnt   <= w_cnt_nxt;
        r_ovf   <= w_ovf_nxt;
      end
      if (w_finish) begin
        r_data_out <= w_shift_nxt;
        r_bit_cnt  <= w_cnt_nxt;
      end
      // The synchroniser restarts from zero after reset, so a level low is
      // only trusted once the chain and edge registers have refilled; until
      // then an enable held high through reset would look like a new edge.
      r_warm <= {r_warm[WARM_W-2:0], 1'b1};
      if (w_abort)                             r_need_low <= 1'b1;
      else if (r_warm[WARM_W-1] && !w_en_level) r_need_low <= 1'b0;
    end
  end

  assign S2P_DATA_OUT = r_data_out;
  assign S2P_Bit_Cnt  = r_bit_cnt;
  assign S2P_Valid    = r_valid;
  assign S2P_Err      = r_err;
  assign S2P_BUSY     = (r_state == ST_RECV);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_s2p_width_rc_module.sv
// Bench for s2p_width_rc_module: drives SPI-style frames (MSB first, data
// set on clock-low phase) and compares every received word against a
// frame-level model of what the link should deliver.
module tb_s2p_width_rc_module;
  import s2p_pkg::*;

  localparam int W      = 16;
  localparam int SYNC   = 2;
  localparam int T      = 2000;
  localparam int EXP_W  = 1 + 8 + W;   // {err, bit_cnt, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          Serial_clk = 1'b0;
  logic          Serial_data = 1'b0;
  logic          Serial_data_en = 1'b0;
  logic [31:0]   S2P_DATA_Width = 32'd16;
  logic [W-1:0]  S2P_DATA_OUT;
  logic          S2P_Valid, S2P_BUSY, S2P_Err;
  logic [7:0]    S2P_Bit_Cnt;
  s2p_state_e    dbg_state;

  s2p_width_rc_module #(
    .SHIFT_REG_WIDTH_MAX(W), .SYNC_STAGES(SYNC), .FIRST_BIT_MSB(1), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .Serial_clk(Serial_clk), .Serial_data(Serial_data), .Serial_data_en(Serial_data_en),
    .S2P_DATA_Width(S2P_DATA_Width),
    .S2P_DATA_OUT(S2P_DATA_OUT), .S2P_Valid(S2P_Valid), .S2P_BUSY(S2P_BUSY),
    .S2P_Err(S2P_Err), .S2P_Bit_Cnt(S2P_Bit_Cnt), .o_dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The first min(n, W) bits sent, as a right-aligned number; the count
  // saturates one past the register size.
  function automatic logic [EXP_W-1:0] model(input logic [31:0] value, input int n,
                                             input logic [31:0] width);
    logic [W-1:0] d;
    logic [7:0]   c;
    logic         e;
    if (n > W) begin
      d = W'((value >> (n - W)) & 32'hFFFF);
      c = 8'(W + 1);
    end else begin
      d = (n == 0) ? '0 : W'(value & ((32'd1 << n) - 32'd1));
      c = 8'(n);
    end
    e = (n == 0) || (n > W) || (width != 32'(n));
    return {e, c, d};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int           n_pushed = 0;
  int           n_valid = 0;
  int           n_spurious = 0;
  int           n_hold_bad = 0;
  int           t_fall = 0;
  int           t_rise = 0;
  bit           tmo_expect = 1'b0;
  logic [W-1:0] last_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      last_data = '0;
    end else if (S2P_Valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        n_spurious++;
        last_data = S2P_DATA_OUT;
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check_eq("data", 32'(S2P_DATA_OUT), 32'(e[W-1:0]));
        check_eq("bit_cnt", 32'(S2P_Bit_Cnt), 32'(e[W+7:W]));
        check_eq("err", 32'(S2P_Err), 32'(e[EXP_W-1]));
        check_eq("busy_in_done", 32'(S2P_BUSY), 32'd0);
        check_eq("valid_latency", 32'(cyc - t_fall), 32'(SYNC + 2));
        last_data = e[W-1:0];
      end
    end else begin
      if (S2P_DATA_OUT !== last_data) n_hold_bad++;
      if (S2P_Err && !tmo_expect) n_spurious++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clock_bits(input logic [31:0] value, input int nbits, input int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      Serial_data = value[i];
      repeat (half) @(negedge clk);
      Serial_clk = 1'b1;
      t_rise = cyc;
      repeat (half) @(negedge clk);
      Serial_clk = 1'b0;
    end
    repeat (half) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] value, input int nbits, input logic [31:0] width,
                            input int half, input int gap, input bit scramble_width);
    exp_q.push_back(model(value, nbits, width));
    n_pushed++;
    S2P_DATA_Width = width;
    Serial_data_en = 1'b1;
    clock_bits(value, nbits, half);
    check_eq("busy_in_frame", 32'(S2P_BUSY), 32'd1);
    if (scramble_width) S2P_DATA_Width = $urandom_range(0, 40);
    Serial_data_en = 1'b0;
    Serial_data = 1'b0;
    t_fall = cyc;
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (4) @(negedge clk);
    check_eq("rst_data", 32'(S2P_DATA_OUT), 32'd0);
    check_eq("rst_valid", 32'(S2P_Valid), 32'd0);
    check_eq("rst_busy", 32'(S2P_BUSY), 32'd0);
    check_eq("rst_err", 32'(S2P_Err), 32'd0);
    check_eq("rst_bit_cnt", 32'(S2P_Bit_Cnt), 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // directed frames
    send_frame(32'hA5C3, 16, 32'd16, 15, 10, 1'b0);   // loop-back word
    send_frame(32'hABC, 12, 32'd16, 5, 10, 1'b0);     // short frame
    send_frame(32'hABCDE, 20, 32'd16, 4, 10, 1'b0);   // overflow
    send_frame(32'h0, 0, 32'd16, 5, 10, 1'b0);        // no bits at all
    send_frame(32'h1, 1, 32'd0, 5, 10, 1'b0);         // width 0
    send_frame(32'h5A5A, 16, 32'd20, 6, 10, 1'b0);    // width above max
    send_frame(32'h8001, 16, 32'd16, 4, 10, 1'b0);    // clean, fastest serial clock

    // reset mid-frame, released with enable still high
    S2P_DATA_Width = 32'd16;
    Serial_data_en = 1'b1;
    clock_bits(32'h12, 8, 5);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_data", 32'(S2P_DATA_OUT), 32'd0);
    check_eq("midrst_bit_cnt", 32'(S2P_Bit_Cnt), 32'd0);
    check_eq("midrst_busy", 32'(S2P_BUSY), 32'd0);
    rst = 1'b1;
    clock_bits(32'h34, 8, 5);
    check_eq("busy_after_rst_release", 32'(S2P_BUSY), 32'd0);
    Serial_data_en = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(32'h1234, 16, 32'd16, 5, 10, 1'b0);

    // back-to-back with a one-cycle enable gap
    send_frame(32'hFFFF, 16, 32'd16, 5, 1, 1'b0);
    send_frame(32'h0001, 16, 32'd16, 5, 10, 1'b0);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      int          n;
      logic [31:0] width;
      n = $urandom_range(0, 20);
      if ($urandom_range(0, 9) < 7 && n >= 1 && n <= W) width = 32'(n);
      else width = $urandom_range(0, 20);
      send_frame($urandom, n, width, $urandom_range(4, 8), $urandom_range(1, 8), 1'b1);
    end

`ifdef S2P_TIMEOUT_EN
    begin
      bit           seen;
      logic [W-1:0] held;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      held = last_data;
      tmo_expect = 1'b1;
      S2P_DATA_Width = 32'd16;
      Serial_data_en = 1'b1;
      clock_bits(32'h15, 5, 5);
      seen = 1'b0;
      for (int i = 0; i < T + 100; i++) begin
        @(negedge clk);
        if (S2P_Err) begin
          seen = 1'b1;
          break;
        end
      end
      check_eq("tmo_err_seen", 32'(seen), 32'd1);
      // stall is measured from the last clock rise at the pins
      check_eq("tmo_latency", 32'(cyc - t_rise), 32'(T + SYNC + 2));
      check_eq("tmo_valid", 32'(S2P_Valid), 32'd0);
      check_eq("tmo_busy", 32'(S2P_BUSY), 32'd0);
      check_eq("tmo_data_held", 32'(S2P_DATA_OUT), 32'(held));
      @(negedge clk);
      check_eq("tmo_err_one_cycle", 32'(S2P_Err), 32'd0);
      Serial_data_en = 1'b0;
      repeat (10) @(negedge clk);
      tmo_expect = 1'b0;
      send_frame(32'hC0DE, 16, 32'd16, 5, 10, 1'b0);
    end
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    check_eq("valid_count", 32'(n_valid), 32'(n_pushed));
    check_eq("spurious_pulses", 32'(n_spurious), 32'd0);
    check_eq("hold_violations", 32'(n_hold_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/s2p_width_rc_module.md
Name: s2p_width_rc_module

Overview:
- Serial-to-parallel receiver: the far end of the 16-bit SPI-style frame link driven by the team's parallel-to-serial transmitter (serial clock, data and active-high data-enable).
- Oversamples the three serial lines on the system clock and deserialises a run-time-configurable number of bits.
- Presents the received word with a one-cycle valid strobe and error flags.
- Used for DAC register read-back (SDO capture) and as a loop-back checker for the configuration path.

Parameters:
- SHIFT_REG_WIDTH_MAX, 16, maximum frame width in bits; sizes the shift register and the data output.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; minimum 2.
- FIRST_BIT_MSB, 1, 1 = first received bit ends in the MSB of the frame; 0 = first bit lands in bit 0.
- TIMEOUT_CYCLES, 2000, clk cycles with enable high and no serial-clock rising edge before the frame is aborted.

Ports:
- clk  input  1  system clock, 120 MHz.
- rst  input  1  reset, synchronous, active-low.
- Serial_clk  input  1  serial clock, asynchronous to clk, idle low.
- Serial_data  input  1  serial data, valid at the Serial_clk rising edge.
- Serial_data_en  input  1  frame enable, active high; equals ~CS_n.
- S2P_DATA_Width  input  32  expected bit count, 1..SHIFT_REG_WIDTH_MAX; sampled at frame start.
- S2P_DATA_OUT  output  SHIFT_REG_WIDTH_MAX  received word, right-aligned, unused MSBs zero.
- S2P_Valid  output  1  one-cycle pulse when S2P_DATA_OUT updates.
- S2P_BUSY  output  1  high while a frame is in progress.
- S2P_Err  output  1  one-cycle pulse on a bad frame, coincident with S2P_Valid or with the abort.
- S2P_Bit_Cnt  output  8  bits captured in the last completed frame.

Behaviour:
- Reset (rst low at a clk edge):
  - S2P_DATA_OUT=0, S2P_Valid=0, S2P_BUSY=0, S2P_Err=0, S2P_Bit_Cnt=0.
  - Synchroniser chains cleared; state = IDLE.
  - Reset asserted mid-frame discards the partial word with no Valid and no Err. After release, the receiver waits in IDLE for a fresh enable rising edge; an enable already high at release is ignored.
- Input path: each input passes through SYNC_STAGES flops. One further register provides edge detection on the synchronised clock and enable.
- State machine IDLE -> RECV -> DONE -> IDLE:
  - IDLE: on the enable rising edge, latch S2P_DATA_Width, clear the shift register and bit counter, BUSY=1, go to RECV.
  - RECV, on each serial-clock rising edge: shift in the synchronised data and increment the counter. Bits beyond SHIFT_REG_WIDTH_MAX are dropped, set an overflow flag, and the counter saturates at SHIFT_REG_WIDTH_MAX+1.
  - RECV, on the enable falling edge: go to DONE. A serial-clock rising edge in the same cycle is captured first.
  - DONE, one cycle:
    - S2P_DATA_OUT is the shift register right-aligned; order per FIRST_BIT_MSB.
    - S2P_Bit_Cnt is the counter value; S2P_Valid=1; BUSY=0.
    - S2P_Err=1 if count != latched width, or overflow, or count = 0.
- Latency: S2P_Valid rises SYNC_STAGES+2 clk cycles after the enable falling edge at the input pins.
- S2P_DATA_OUT and S2P_Bit_Cnt hold their values until the next DONE.
- Width input: a latched width of 0, or greater than SHIFT_REG_WIDTH_MAX, flags Err at DONE; the captured data is still output.
- Back-to-back frames: an enable rising edge arriving in the DONE cycle is honoured, and the next cycle enters RECV. A minimum enable-low gap of 1 synchronised cycle is required.
- Serial-clock constraint: serial-clock frequency no higher than clk/8, so high and low phases each span at least 3 samples.

Optional Feature:
- Macro: S2P_TIMEOUT_EN.
- Defined: a watchdog in RECV counts clk cycles since the last serial-clock rising edge and reloads on each edge. Reaching TIMEOUT_CYCLES causes:
  - return to IDLE, BUSY=0;
  - S2P_Err pulses for 1 cycle with S2P_Valid=0;
  - data outputs unchanged.
  - The receiver then requires an enable low before the next frame.
- Not defined: no watchdog; RECV waits indefinitely for the enable falling edge; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package s2p_pkg holds:
  - state encoding constants ST_IDLE, ST_RECV, ST_DONE;
  - bit-counter width;
  - default SYNC_STAGES.
- One natural sub-module, s2p_sync_edge: parameterised N-stage synchroniser with registered rise and fall pulses. It is instantiated for Serial_clk and Serial_data_en; data uses the synchroniser only.

Test Plan:
- Loop-back: transmitter sends 16'hA5C3 at 1 MHz with width 16. Required: Valid pulse, S2P_DATA_OUT=16'hA5C3 (FIRST_BIT_MSB=1), S2P_Bit_Cnt=16, Err=0.
- Short frame: width input 16, enable dropped after 12 bits of 12'hABC. Required: S2P_DATA_OUT=16'h0ABC, Bit_Cnt=12, Valid and Err high in the same cycle.
- Overflow: 20 clocks sent with width 16. Required: first 16 bits kept, Bit_Cnt=17 (saturated), Err=1.
- Reset mid-frame: rst low after 8 bits, then released while enable is still high. Required: no Valid or Err; the next full frame 16'h1234 is received correctly.
- Back-to-back: two frames 16'hFFFF then 16'h0001 with a 1-cycle enable gap. Required: two Valid pulses, outputs 16'hFFFF then 16'h0001, no Err.
- With S2P_TIMEOUT_EN and TIMEOUT_CYCLES=2000: enable held high, clock stalled after 5 bits. Required: Err pulses at stall+2000 clk, Valid=0, BUSY falls, S2P_DATA_OUT unchanged.
